// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter.
//   state_t      : controller states (IDLE / MAC / OUT)
//   acc_width()  : lossless accumulator width for a given data/coef/tap count
//   coef_reset() : identity-filter reset value per tap (tap 0 = 1, rest 0)
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int COEF_IDENTITY_TAP0 = 1;

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   function automatic int coef_reset(input int tap);
      return (tap == 0) ? COEF_IDENTITY_TAP0 : 0;
   endfunction

endpackage

// File: rtl/fir_tdm_mac_coef_bank.sv
// Coefficient register file for the TDM FIR.
//   clk, reset : clock, asynchronous active-high reset (restores identity filter)
//   idle       : writes are accepted only while the controller is idle
//   we/addr/wdata : write port
//   rd_idx/rd_data: combinational read of the tap currently being multiplied
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   localparam int KW    = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     idle,
   input  logic                     we,
   input  logic [KW-1:0]            addr,
   input  logic signed [COEF_W-1:0] wdata,
   input  logic [KW-1:0]            rd_idx,
   output logic signed [COEF_W-1:0] rd_data
);

   logic signed [COEF_W-1:0] coef [TAPS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < TAPS; t++) begin
            coef[t] <= COEF_W'(coef_reset(t));
         end
      end else if (we && idle) begin
         coef[addr] <= wdata;
      end
   end

   assign rd_data = coef[rd_idx];

endmodule

// File: rtl/fir_tdm_mac.sv
// Multi-channel time-multiplexed FIR with one shared multiplier (one tap per cycle).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_data sample for channel in_ch
//   coef_we/coef_addr/coef_wdata : coefficient write port (effective in IDLE only)
//   out_valid/out_ready : output handshake; out_data result for channel out_ch
//   busy                : controller not idle
// Build option: define FIR_ROUND_SAT_EN to round (half-up), shift by SHIFT and
// saturate the output to OUT_W bits; otherwise out_data is the raw accumulator.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes allowed
// MAC   | one tap per cycle, k = 0..TAPS-1
// OUT   | result held until out_ready
module fir_tdm_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int CH     = 2,
   parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS),
   parameter int OUT_W  = ACC_W,
   parameter int SHIFT  = 15,
   localparam int CHW   = (CH > 1) ? $clog2(CH) : 1,
   localparam int KW    = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic [CHW-1:0]           in_ch,
   input  logic                     coef_we,
   input  logic [KW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [CHW-1:0]           out_ch,
   output logic                     busy
);

   localparam int PW = DATA_W + COEF_W;
   localparam logic [CHW:0] CH_LIM = (CHW+1)'(CH);

   state_t                   state;
   logic [CHW-1:0]           ch;
   logic [KW-1:0]            k;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] x [CH][TAPS];

   logic signed [DATA_W-1:0] x_sel;
   logic signed [COEF_W-1:0] coef_k;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [OUT_W-1:0]  result;
   logic                     accept;
   logic                     ch_ok;

   assign in_ready = (state == IDLE) && !reset;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   // Samples for non-existent channels are consumed but otherwise dropped.
   assign ch_ok    = ({1'b0, in_ch} < CH_LIM);

   fir_coef_bank #(
      .COEF_W (COEF_W),
      .TAPS   (TAPS)
   ) u_coef_bank (
      .clk     (clk),
      .reset   (reset),
      .idle    (state == IDLE),
      .we      (coef_we),
      .addr    (coef_addr),
      .wdata   (coef_wdata),
      .rd_idx  (k),
      .rd_data (coef_k)
   );

   always_comb begin
      x_sel = '0;
      for (int c = 0; c < CH; c++) begin
         if (ch == CHW'(c)) begin
            x_sel = x[c][k];
         end
      end
   end

   // Operands are sign-extended to the full product width before multiplying.
   assign prod = $signed({{COEF_W{x_sel[DATA_W-1]}}, x_sel})
               * $signed({{DATA_W{coef_k[COEF_W-1]}}, coef_k});
   assign acc_next = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef FIR_ROUND_SAT_EN
   localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) << (SHIFT-1);
   localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W:0] rounded;
   logic signed [ACC_W:0] shifted;

   // One guard bit so the rounding add cannot wrap.
   assign rounded = {acc_next[ACC_W-1], acc_next} + RND;
   assign shifted = rounded >>> SHIFT;

   always_comb begin
      if (shifted > OUT_MAX) begin
         result = OUT_MAX[OUT_W-1:0];
      end else if (shifted < OUT_MIN) begin
         result = OUT_MIN[OUT_W-1:0];
      end else begin
         result = shifted[OUT_W-1:0];
      end
   end
`else
   logic shift_unused;
   assign shift_unused = (SHIFT != 0);
   assign result       = acc_next[OUT_W-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ch        <= '0;
         k         <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         for (int c = 0; c < CH; c++) begin
            for (int t = 0; t < TAPS; t++) begin
               x[c][t] <= '0;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept && ch_ok) begin
                  for (int c = 0; c < CH; c++) begin
                     if (in_ch == CHW'(c)) begin
                        for (int t = TAPS-1; t > 0; t--) begin
                           x[c][t] <= x[c][t-1];
                        end
                        x[c][0] <= in_data;
                     end
                  end
                  ch    <= in_ch;
                  acc   <= '0;
                  k     <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc_next;
               k   <= k + 1'b1;
               if (k == KW'(TAPS-1)) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
                  out_ch    <= ch;
                  out_data  <= result;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac in its default build (8 taps, 2 channels, raw output).
module tb_fir_tdm_mac;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_data = '0;
   logic [0:0]         in_ch = '0;
   logic               coef_we = 1'b0;
   logic [2:0]         coef_addr = '0;
   logic signed [15:0] coef_wdata = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [34:0] out_data;
   logic [0:0]         out_ch;
   logic               busy;

   int n_vec = 0;
   int n_err = 0;

   fir_tdm_mac dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ch      (in_ch),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ch     (out_ch),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic write_coef(input logic [2:0] a, input logic signed [15:0] v);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = a; coef_wdata = v;
      @(posedge clk);
      #1 coef_we = 1'b0;
   endtask

   task automatic send(input logic signed [15:0] d, input logic c);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("send_ready", {63'd0, in_ready}, 64'sd1);
      in_valid = 1'b1; in_data = d; in_ch = c;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Waits for out_valid, counting edges from the current point.
   task automatic expect_out(input string tag, input logic signed [63:0] exp,
                             input logic c, input int exp_lat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check(tag, 64'(out_data), exp);
      check({tag, "_ch"}, {63'd0, out_ch}, {63'd0, c});
      if (out_ready) begin
         @(posedge clk);
         #1;
         check({tag, "_clr"}, {63'd0, out_valid}, 64'sd0);
      end
   endtask

   initial begin
      logic signed [63:0] t2_exp [8];
      t2_exp[0] = 2; t2_exp[1] = 4; t2_exp[2] = 4; t2_exp[3] = 2;
      t2_exp[4] = 0; t2_exp[5] = 0; t2_exp[6] = 0; t2_exp[7] = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'sd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'sd0);
      check("rst_busy", {63'd0, busy}, 64'sd0);
      check("rst_out_data", 64'(out_data), 64'sd0);
      check("rst_out_ch", {63'd0, out_ch}, 64'sd0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("idle_in_ready", {63'd0, in_ready}, 64'sd1);

      // 1: identity filter passes samples through
      send(16'sd100, 1'b0);
      expect_out("ident_100", 64'sd100, 1'b0, 8);
      send(-16'sd200, 1'b0);
      expect_out("ident_m200", -64'sd200, 1'b0, 8);

      // 2: impulse response on ch1
      write_coef(3'd0, 16'sd2); write_coef(3'd1, 16'sd4);
      write_coef(3'd2, 16'sd4); write_coef(3'd3, 16'sd2);
      for (int i = 0; i < 8; i++) begin
         send((i == 0) ? 16'sd1 : 16'sd0, 1'b1);
         expect_out($sformatf("impulse_%0d", i), t2_exp[i], 1'b1, 8);
      end

      // 3: interleaved channels, clean history, all-ones coefficients
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) write_coef(3'(i), 16'sd1);
      for (int i = 0; i < 8; i++) begin
         send((i == 0) ? 16'sd10 : 16'sd0, 1'b0);
         expect_out($sformatf("ch0_imp_%0d", i), 64'sd10, 1'b0, 8);
         send(16'sd3, 1'b1);
         expect_out($sformatf("ch1_ramp_%0d", i), 64'(3 * (i + 1)), 1'b1, 8);
      end

      // 4: output stall; ch1 history is eight 3s
      out_ready = 1'b0;
      send(16'sd5, 1'b1);
      expect_out("stall", 64'sd26, 1'b1, 8);
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'sd7; in_ch = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall_valid_%0d", i), {63'd0, out_valid}, 64'sd1);
         check($sformatf("stall_data_%0d", i), 64'(out_data), 64'sd26);
         check($sformatf("stall_ch_%0d", i), {63'd0, out_ch}, 64'sd1);
         check($sformatf("stall_inrdy_%0d", i), {63'd0, in_ready}, 64'sd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hs_valid", {63'd0, out_valid}, 64'sd0);
      check("hs_in_ready", {63'd0, in_ready}, 64'sd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("hs_accept_busy", {63'd0, busy}, 64'sd1);
      expect_out("stall_next", 64'sd30, 1'b1, 8);

      // 5: full-scale negative samples and coefficients on ch0
      for (int i = 0; i < 8; i++) write_coef(3'(i), -16'sd32768);
      for (int i = 0; i < 8; i++) begin
         send(-16'sd32768, 1'b0);
         expect_out($sformatf("fullscale_%0d", i), 64'sd1073741824 * (i + 1), 1'b0, 8);
      end

      // 6a: identity again; write to tap 7 during MAC must be ignored
      write_coef(3'd0, 16'sd1);
      for (int i = 1; i < 8; i++) write_coef(3'(i), 16'sd0);
      send(16'sd50, 1'b1);
      @(negedge clk);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 3'd7; coef_wdata = 16'sd9;
      @(posedge clk);
      #1 coef_we = 1'b0;
      expect_out("we_in_mac", 64'sd50, 1'b1, 6);

      // 6b: write on the acceptance edge is used by that sample
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'sd4; in_ch = 1'b1;
      coef_we = 1'b1; coef_addr = 3'd1; coef_wdata = 16'sd2;
      @(posedge clk);
      #1;
      in_valid = 1'b0; coef_we = 1'b0;
      expect_out("we_same_edge", 64'sd104, 1'b1, 8);

      // 6c: reset in the middle of MAC
      send(16'sd20, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_valid", {63'd0, out_valid}, 64'sd0);
      check("midrst_busy", {63'd0, busy}, 64'sd0);
      check("midrst_in_ready", {63'd0, in_ready}, 64'sd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send(16'sd5, 1'b1);
      expect_out("post_rst_a", 64'sd5, 1'b1, 8);
      send(16'sd6, 1'b1);
      expect_out("post_rst_b", 64'sd6, 1'b1, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
